// File: rtl/coherent_memory_control_n_pkg.sv
// Shared types for the snooping memory controller: word, RAM handshake state,
// controller FSM state and an index-width helper.
package coherent_memory_control_n_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, SNOOP, CWB, CLW, SWB} mc_state_t;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coherent_memory_control_n_if.sv
// Cache/RAM side bus of the memory controller.
// master: per-CPU L1 caches plus the RAM (drive requests, ramload, ramstate)
// slave : the controller (drives waits, load data, snoop controls, RAM request)
// Signals: iREN/iaddr/iwait/iload       instruction fetch, one lane per CPU
//          dREN/dWEN/daddr/dstore/dwait/dload  data block transfers
//          cctrans/ccwrite/ccwait/ccinv/ccsnoopaddr  coherence snoop handshake
//          ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  shared RAM port
interface coherent_memory_control_n_if
  import coherent_memory_control_n_pkg::*;
#(
  parameter int unsigned CPUS = 4
) ();

  logic [CPUS-1:0]  iREN;
  word_t [CPUS-1:0] iaddr;
  logic [CPUS-1:0]  iwait;
  word_t [CPUS-1:0] iload;

  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] dload;

  logic [CPUS-1:0]  cctrans;
  logic [CPUS-1:0]  ccwrite;
  logic [CPUS-1:0]  ccwait;
  logic [CPUS-1:0]  ccinv;
  word_t [CPUS-1:0] ccsnoopaddr;

  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  word_t            ramload;
  ramstate_t        ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/coherent_memory_control_n_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr_i,
// wrapping modulo N.
// Ports: req_i  request vector
//        ptr_i  index with highest priority this cycle
//        idx_o  granted index (0 when nothing requests)
//        valid_o at least one request present
module coherent_memory_control_n_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned pos;

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      pos = 32'(ptr_i) + 32'(k);
      if (pos >= N) pos = pos - N;
      if (req_i[IW'(pos)]) begin
        idx_o   = IW'(pos);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coherent_memory_control_n.sv
// N-CPU snooping memory controller. Arbitrates instruction fetches and data
// block transfers onto one RAM port, snoops the other caches on a data read
// miss and forwards a Modified block cache-to-cache while writing it back.
// Ports: CLK  clock, all state on the rising edge
//        RST  synchronous active-high reset; also masks the RAM request
//        bus  controller side (slave modport) of the cache/RAM interface
module coherent_memory_control_n
  import coherent_memory_control_n_pkg::*;
#(
  parameter int unsigned CPUS        = 4,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input logic                          CLK,
  input logic                          RST,
  coherent_memory_control_n_if.slave   bus
);

  localparam int unsigned IW   = idx_w(CPUS);
  localparam int unsigned CW   = idx_w(BLOCK_WORDS);
  localparam int unsigned LAST = BLOCK_WORDS - 1;

  mc_state_t       state_q, state_d;
  logic [IW-1:0]   dgrant_q, dgrant_d;
  logic [IW-1:0]   dptr_q, dptr_d;
  logic [IW-1:0]   iptr_q, iptr_d;
  logic [IW-1:0]   igrant_q, igrant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            ifetch_q, ifetch_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;

  logic [IW-1:0]   d_idx, i_idx, own_idx;
  logic            d_valid, i_valid, own_valid;
  logic            access;
  logic            last_word;

  assign access    = (bus.ramstate == ACCESS);
  assign last_word = (wcnt_q == CW'(LAST));

  function automatic logic [IW-1:0] nxt_idx(input logic [IW-1:0] i);
    return (32'(i) == CPUS - 1) ? '0 : i + IW'(1);
  endfunction

  coherent_memory_control_n_rr_arbiter #(.N(CPUS), .IW(IW)) u_darb (
    .req_i   (bus.dREN | bus.dWEN),
    .ptr_i   (dptr_q),
    .idx_o   (d_idx),
    .valid_o (d_valid)
  );

  coherent_memory_control_n_rr_arbiter #(.N(CPUS), .IW(IW)) u_iarb (
    .req_i   (bus.iREN),
    .ptr_i   (iptr_q),
    .idx_o   (i_idx),
    .valid_o (i_valid)
  );

  // Lowest-index snooped cache (not the requester) reporting a Modified copy.
  always_comb begin
    own_idx   = '0;
    own_valid = 1'b0;
    for (int j = int'(CPUS) - 1; j >= 0; j--) begin
      if (IW'(j) != dgrant_q && bus.ccwrite[IW'(j)]) begin
        own_idx   = IW'(j);
        own_valid = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      dgrant_q <= '0;
      dptr_q   <= '0;
      iptr_q   <= '0;
      igrant_q <= '0;
      owner_q  <= '0;
      ifetch_q <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      dgrant_q <= dgrant_d;
      dptr_q   <= dptr_d;
      iptr_q   <= iptr_d;
      igrant_q <= igrant_d;
      owner_q  <= owner_d;
      ifetch_q <= ifetch_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Next-state logic; BUSY/ERROR simply leave everything as is.
  always_comb begin
    state_d  = state_q;
    dgrant_d = dgrant_q;
    dptr_d   = dptr_q;
    iptr_d   = iptr_q;
    igrant_d = igrant_q;
    owner_d  = owner_q;
    ifetch_d = ifetch_q;
    wcnt_d   = wcnt_q;
    case (state_q)
      IDLE: begin
        if (ifetch_q) begin
          // A fetch already on the RAM port runs to its ACCESS before data may win.
          if (access) begin
            ifetch_d = 1'b0;
            iptr_d   = nxt_idx(igrant_q);
          end
        end else if (d_valid) begin
          dgrant_d = d_idx;
          state_d  = bus.dWEN[d_idx] ? CWB : SNOOP;
        end else if (i_valid) begin
          if (access) begin
            iptr_d = nxt_idx(i_idx);
          end else begin
            ifetch_d = 1'b1;
            igrant_d = i_idx;
          end
        end
      end
      SNOOP: begin
        wcnt_d = '0;
        if (own_valid) begin
          owner_d = own_idx;
          state_d = SWB;
        end else begin
          state_d = CLW;
        end
      end
      CWB, CLW, SWB: begin
        if (access) begin
          if (last_word) begin
            wcnt_d  = '0;
            state_d = IDLE;
            dptr_d  = nxt_idx(dgrant_q);
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; RST forces the idle values in the same cycle.
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ccwait   = '0;
    bus.ccinv    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    for (int i = 0; i < int'(CPUS); i++) begin
      bus.iload[i]       = bus.ramload;
      bus.dload[i]       = (state_q == SWB) ? bus.dstore[owner_q] : bus.ramload;
      bus.ccsnoopaddr[i] = bus.daddr[dgrant_q];
    end
    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (ifetch_q) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr[igrant_q];
            if (access) bus.iwait[igrant_q] = 1'b0;
          end else if (!d_valid && i_valid) begin
            bus.ramREN  = 1'b1;
            bus.ramaddr = bus.iaddr[i_idx];
            if (access) bus.iwait[i_idx] = 1'b0;
          end
        end
        SNOOP: begin
          for (int j = 0; j < int'(CPUS); j++) begin
            if (IW'(j) != dgrant_q) begin
              bus.ccwait[IW'(j)] = 1'b1;
              bus.ccinv[IW'(j)]  = bus.ccwrite[dgrant_q] & bus.cctrans[dgrant_q];
            end
          end
        end
        CWB: begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[dgrant_q];
          bus.ramstore = bus.dstore[dgrant_q];
          if (access) bus.dwait[dgrant_q] = 1'b0;
        end
        CLW: begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.daddr[dgrant_q];
          if (access) bus.dwait[dgrant_q] = 1'b0;
        end
        SWB: begin
          // Owner's word goes to RAM and to the requester in one access.
          bus.ccwait[owner_q] = 1'b1;
          bus.ramWEN          = 1'b1;
          bus.ramaddr         = bus.daddr[dgrant_q];
          bus.ramstore        = bus.dstore[owner_q];
          if (access) begin
            bus.dwait[dgrant_q] = 1'b0;
            bus.dwait[owner_q]  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coherent_memory_control_n.sv
// Directed bench for coherent_memory_control_n (CPUS=4, BLOCK_WORDS=2).
// RAM model: every request sees BUSY, BUSY, ACCESS; unwritten words read
// back as 32'hA000_0000 + word index (byte address >> 2).
module tb_coherent_memory_control_n;
  import coherent_memory_control_n_pkg::*;

  localparam int unsigned CPUS = 4;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  coherent_memory_control_n_if #(.CPUS(CPUS)) bus ();

  coherent_memory_control_n #(.CPUS(CPUS), .BLOCK_WORDS(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [31:0]  wmem [256];
  logic [255:0] wvalid;
  logic [7:0]   ridx;
  int unsigned  rcnt;

  assign ridx         = bus.ramaddr[9:2];
  assign bus.ramload  = wvalid[ridx] ? wmem[ridx] : (32'hA000_0000 | 32'(ridx));
  assign bus.ramstate = !(bus.ramREN || bus.ramWEN) ? FREE : ((rcnt == 2) ? ACCESS : BUSY);

  always @(posedge clk) begin
    if (rst || !(bus.ramREN || bus.ramWEN) || rcnt == 2) rcnt <= 0;
    else rcnt <= rcnt + 1;
    if (rst) wvalid <= '0;
    else if (bus.ramWEN && bus.ramstate == ACCESS) begin
      wmem[ridx]   <= bus.ramstore;
      wvalid[ridx] <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iREN    = '0;
    bus.dREN    = '0;
    bus.dWEN    = '0;
    bus.cctrans = '0;
    bus.ccwrite = '0;
    bus.iaddr   = '0;
    bus.daddr   = '0;
    bus.dstore  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  // Advance until some iwait/dwait bit is low; ok=0 if the budget runs out.
  task automatic wait_any(output bit ok);
    ok = 1'b0;
    #1;
    for (int n = 0; n < 12; n++) begin
      if (!(&bus.iwait) || !(&bus.dwait)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.iREN = 4'hF;
    bus.dREN = 4'b0100;
    step();
    tests++; if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin fails++;
      $display("FAIL reset_ram got REN=%b WEN=%b exp 0 0", bus.ramREN, bus.ramWEN); end
    tests++; if (bus.iwait !== 4'hF || bus.dwait !== 4'hF) begin fails++;
      $display("FAIL reset_waits got i=%b d=%b exp 1111 1111", bus.iwait, bus.dwait); end
    tests++; if (bus.ccwait !== 4'h0 || bus.ccinv !== 4'h0) begin fails++;
      $display("FAIL reset_cc got wait=%b inv=%b exp 0000 0000", bus.ccwait, bus.ccinv); end
    do_reset();
  endtask

  task automatic test_ifetch();
    bit ok;
    logic [3:0] expw;
    do_reset();
    for (int k = 0; k < 4; k++) bus.iaddr[k] = 32'h200 + 32'(k * 4);
    bus.iREN = 4'hF;
    for (int n = 0; n < 5; n++) begin
      int k;
      k = n % 4;
      expw = ~(4'b0001 << k);
      wait_any(ok);
      tests++; if (!ok) begin fails++; $display("FAIL ifetch_timeout got none exp fetch %0d", n); end
      tests++; if (bus.iwait !== expw) begin fails++;
        $display("FAIL ifetch_iwait got %b exp %b", bus.iwait, expw); end
      tests++; if (bus.ramaddr !== 32'h200 + 32'(k * 4)) begin fails++;
        $display("FAIL ifetch_addr got %h exp %h", bus.ramaddr, 32'h200 + 32'(k * 4)); end
      tests++; if (bus.iload[k] !== 32'hA000_0080 + 32'(k)) begin fails++;
        $display("FAIL ifetch_load got %h exp %h", bus.iload[k], 32'hA000_0080 + 32'(k)); end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_clean_read();
    bit ok;
    do_reset();
    bus.dREN[2]  = 1'b1;
    bus.daddr[2] = 32'h100;
    #1;
    tests++; if (bus.ramREN !== 1'b0 || bus.dwait !== 4'hF) begin fails++;
      $display("FAIL clean_idle got REN=%b dwait=%b exp 0 1111", bus.ramREN, bus.dwait); end
    step();
    tests++; if (bus.ccwait !== 4'b1011 || bus.ccinv !== 4'b0000) begin fails++;
      $display("FAIL clean_snoop got ccwait=%b ccinv=%b exp 1011 0000", bus.ccwait, bus.ccinv); end
    tests++; if (bus.ccsnoopaddr[0] !== 32'h100) begin fails++;
      $display("FAIL clean_snoopaddr got %h exp 00000100", bus.ccsnoopaddr[0]); end
    step();
    tests++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h100) begin fails++;
      $display("FAIL clean_clw got REN=%b addr=%h exp 1 00000100", bus.ramREN, bus.ramaddr); end
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b1011 || bus.dload[2] !== 32'hA000_0040) begin fails++;
      $display("FAIL clean_word0 got dwait=%b dload=%h exp 1011 a0000040", bus.dwait, bus.dload[2]); end
    step();
    bus.daddr[2] = 32'h104;
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b1011 || bus.dload[2] !== 32'hA000_0041) begin fails++;
      $display("FAIL clean_word1 got dwait=%b dload=%h exp 1011 a0000041", bus.dwait, bus.dload[2]); end
    step();
    bus.dREN = '0;
    #1;
    tests++; if (bus.dwait !== 4'hF || bus.ramREN !== 1'b0) begin fails++;
      $display("FAIL clean_done got dwait=%b REN=%b exp 1111 0", bus.dwait, bus.ramREN); end
  endtask

  task automatic test_snoop_wb();
    bit ok;
    do_reset();
    bus.dREN[1]   = 1'b1;
    bus.daddr[1]  = 32'h140;
    bus.ccwrite[3] = 1'b1;
    bus.dstore[3] = 32'hDEAD_0000;
    step();
    tests++; if (bus.ccwait !== 4'b1101) begin fails++;
      $display("FAIL swb_snoop got ccwait=%b exp 1101", bus.ccwait); end
    step();
    tests++; if (bus.ccwait !== 4'b1000 || bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin fails++;
      $display("FAIL swb_state got ccwait=%b WEN=%b REN=%b exp 1000 1 0", bus.ccwait, bus.ramWEN, bus.ramREN); end
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b0101 || bus.dload[1] !== 32'hDEAD_0000) begin fails++;
      $display("FAIL swb_word0 got dwait=%b dload=%h exp 0101 dead0000", bus.dwait, bus.dload[1]); end
    step();
    bus.daddr[1]  = 32'h144;
    bus.dstore[3] = 32'hDEAD_0001;
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b0101 || bus.dload[1] !== 32'hDEAD_0001) begin fails++;
      $display("FAIL swb_word1 got dwait=%b dload=%h exp 0101 dead0001", bus.dwait, bus.dload[1]); end
    step();
    clear_inputs();
    #1;
    tests++; if (wmem[8'h50] !== 32'hDEAD_0000 || wmem[8'h51] !== 32'hDEAD_0001) begin fails++;
      $display("FAIL swb_ram got %h %h exp dead0000 dead0001", wmem[8'h50], wmem[8'h51]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    bus.dWEN[0]   = 1'b1;
    bus.daddr[0]  = 32'h180;
    bus.dstore[0] = 32'hC000_0000;
    bus.dREN[3]   = 1'b1;
    bus.daddr[3]  = 32'h1C0;
    bus.iREN[1]   = 1'b1;
    bus.iaddr[1]  = 32'h240;
    #1;
    tests++; if (bus.ramREN !== 1'b0 || bus.iwait !== 4'hF) begin fails++;
      $display("FAIL b2b_idle got REN=%b iwait=%b exp 0 1111", bus.ramREN, bus.iwait); end
    step();
    tests++; if (bus.ramWEN !== 1'b1 || bus.ramaddr !== 32'h180 || bus.ramstore !== 32'hC000_0000) begin fails++;
      $display("FAIL b2b_cwb got WEN=%b addr=%h data=%h exp 1 00000180 c0000000", bus.ramWEN, bus.ramaddr, bus.ramstore); end
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b1110 || bus.iwait !== 4'hF) begin fails++;
      $display("FAIL b2b_cwb0 got dwait=%b iwait=%b exp 1110 1111", bus.dwait, bus.iwait); end
    step();
    bus.daddr[0]  = 32'h184;
    bus.dstore[0] = 32'hC000_0001;
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b1110) begin fails++;
      $display("FAIL b2b_cwb1 got dwait=%b exp 1110", bus.dwait); end
    step();
    bus.dWEN[0] = 1'b0;
    #1;
    tests++; if (bus.ramREN !== 1'b0 || bus.iwait !== 4'hF) begin fails++;
      $display("FAIL b2b_starve got REN=%b iwait=%b exp 0 1111", bus.ramREN, bus.iwait); end
    step();
    tests++; if (bus.ccwait !== 4'b0111) begin fails++;
      $display("FAIL b2b_snoop got ccwait=%b exp 0111", bus.ccwait); end
    step();
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b0111 || bus.dload[3] !== 32'hA000_0070) begin fails++;
      $display("FAIL b2b_clw0 got dwait=%b dload=%h exp 0111 a0000070", bus.dwait, bus.dload[3]); end
    step();
    bus.daddr[3] = 32'h1C4;
    wait_any(ok);
    tests++; if (!ok || bus.dload[3] !== 32'hA000_0071) begin fails++;
      $display("FAIL b2b_clw1 got dload=%h exp a0000071", bus.dload[3]); end
    step();
    bus.dREN = '0;
    wait_any(ok);
    tests++; if (!ok || bus.iwait !== 4'b1101 || bus.iload[1] !== 32'hA000_0090) begin fails++;
      $display("FAIL b2b_ifetch got iwait=%b iload=%h exp 1101 a0000090", bus.iwait, bus.iload[1]); end
    tests++; if (wmem[8'h60] !== 32'hC000_0000 || wmem[8'h61] !== 32'hC000_0001) begin fails++;
      $display("FAIL b2b_ram got %h %h exp c0000000 c0000001", wmem[8'h60], wmem[8'h61]); end
    step();
    clear_inputs();
  endtask

  task automatic test_invalidate();
    bit ok;
    do_reset();
    bus.dREN[0]    = 1'b1;
    bus.daddr[0]   = 32'h100;
    bus.cctrans[0] = 1'b1;
    bus.ccwrite[0] = 1'b1;
    step();
    tests++; if (bus.ccinv !== 4'b1110 || bus.ccwait !== 4'b1110) begin fails++;
      $display("FAIL inv_snoop got ccinv=%b ccwait=%b exp 1110 1110", bus.ccinv, bus.ccwait); end
    bus.cctrans = '0;
    bus.ccwrite = '0;
    step();
    tests++; if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0) begin fails++;
      $display("FAIL inv_clw got REN=%b WEN=%b exp 1 0", bus.ramREN, bus.ramWEN); end
    wait_any(ok);
    step();
    bus.daddr[0] = 32'h104;
    wait_any(ok);
    tests++; if (!ok || bus.dwait !== 4'b1110 || bus.dload[0] !== 32'hA000_0041) begin fails++;
      $display("FAIL inv_word1 got dwait=%b dload=%h exp 1110 a0000041", bus.dwait, bus.dload[0]); end
    step();
    clear_inputs();
  endtask

  // Continues from test_invalidate: the round-robin pointer now sits at 1.
  task automatic test_reset_mid();
    bit ok;
    bus.dREN[2]  = 1'b1;
    bus.daddr[2] = 32'h100;
    step();
    step();
    wait_any(ok);
    step();
    bus.daddr[2] = 32'h104;
    #1;
    tests++; if (bus.ramREN !== 1'b1) begin fails++;
      $display("FAIL rmid_word1 got REN=%b exp 1", bus.ramREN); end
    rst = 1'b1;
    #1;
    tests++; if (bus.ramREN !== 1'b0 || bus.dwait !== 4'hF) begin fails++;
      $display("FAIL rmid_drop got REN=%b dwait=%b exp 0 1111", bus.ramREN, bus.dwait); end
    step();
    rst = 1'b0;
    bus.dREN = 4'b1001;
    #1;
    tests++; if (bus.ramREN !== 1'b0 || bus.iwait !== 4'hF || bus.dwait !== 4'hF || bus.ccwait !== 4'h0) begin fails++;
      $display("FAIL rmid_idle got REN=%b iwait=%b dwait=%b ccwait=%b exp 0 1111 1111 0000",
               bus.ramREN, bus.iwait, bus.dwait, bus.ccwait); end
    step();
    tests++; if (bus.ccwait !== 4'b1110) begin fails++;
      $display("FAIL rmid_dptr got ccwait=%b exp 1110", bus.ccwait); end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_ifetch();
    test_clean_read();
    test_snoop_wb();
    test_back_to_back();
    test_invalidate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
